resp_adapter: RTL and testbench

RESP_ADAPTER -- requirements
Module: resp_adapter

---
 rtl/resp_adapter.sv | 60 ++++++
 tb/tb_resp_adapter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/resp_adapter.sv
// 56-to-64-bit response gearbox: packs 7-byte input words into 8-byte output words.
// Optional idle-cycle residue flush is enabled by defining RESP_ADAPTER_FLUSH_EN.
module resp_adapter (
    input  logic        clk,
    input  logic        rst,
    input  logic [55:0] in,
    input  logic        ivalid,
    output logic [63:0] out,
    output logic        ovalid
);

    // Residue is kept left-justified with zeroed tail bytes so it can be OR-merged.
    logic [55:0]  res;
    logic [2:0]   cnt;
    logic [2:0]   gap;
    logic [6:0]   shamt;
    logic [111:0] stream;

    always_comb begin
        gap    = 3'd7 - cnt;
        shamt  = {1'b0, gap, 3'b000};
        stream = {res, 56'h0} | ({56'h0, in} << shamt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res    <= '0;
            cnt    <= '0;
            out    <= '0;
            ovalid <= 1'b0;
        end else begin
            ovalid <= 1'b0;
            if (ivalid) begin
                if (cnt == 3'd0) begin
                    res <= in;
                    cnt <= 3'd7;
                end else begin
                    out    <= stream[111:48];
                    ovalid <= 1'b1;
                    res    <= {stream[47:0], 8'h00};
                    cnt    <= cnt - 3'd1;
                end
            end
`ifdef RESP_ADAPTER_FLUSH_EN
            else if (cnt != 3'd0) begin
                out    <= {res, 8'h00};
                ovalid <= 1'b1;
                res    <= '0;
                cnt    <= '0;
            end
`else
            else begin
                res <= res;
                cnt <= cnt;
            end
`endif
        end
    end

endmodule

// File: tb/tb_resp_adapter.sv
// Self-checking bench for resp_adapter: table-driven vectors plus a byte-stream scoreboard.
module tb_resp_adapter;

    logic        clk;
    logic        rst;
    logic [55:0] din;
    logic        ivalid;
    logic [63:0] dout;
    logic        ovalid;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mq[$];
    logic [63:0] sb[$];
    logic [63:0] exp_out;

    typedef struct {
        logic        v;
        logic [55:0] d;
        logic        eov;
        logic [63:0] eout;
    } vec_t;

    vec_t tbl[8];

    resp_adapter dut (
        .clk    (clk),
        .rst    (rst),
        .in     (din),
        .ivalid (ivalid),
        .out    (dout),
        .ovalid (ovalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        exp_out = '0;
    endtask

    task automatic step(input logic v, input logic [55:0] d);
        logic        fire;
        logic [63:0] w;
        int          n;
        ivalid = v;
        din    = d;
        fire   = 1'b0;
        w      = exp_out;
        if (v) begin
            for (int i = 0; i < 7; i++) mq.push_back(d[55-8*i -: 8]);
            if (mq.size() >= 8) begin
                fire = 1'b1;
                for (int i = 0; i < 8; i++) w = {w[55:0], mq.pop_front()};
            end
        end
`ifdef RESP_ADAPTER_FLUSH_EN
        else if (mq.size() > 0) begin
            fire = 1'b1;
            n    = mq.size();
            for (int i = 0; i < 8; i++) w = {w[55:0], (i < n) ? mq.pop_front() : 8'h00};
        end
`endif
        if (fire) sb.push_back(w);
        @(posedge clk);
        #1;
        chk("ovalid", {63'h0, ovalid}, {63'h0, fire});
        if (ovalid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out got %h expected none", dout);
            end else begin
                exp_out = sb.pop_front();
                chk("out", dout, exp_out);
            end
        end else begin
            if (fire) void'(sb.pop_front());
            if (fire) exp_out = w;
            chk("out_hold", dout, exp_out);
        end
    endtask

    initial begin
        logic [55:0] cw;
        logic [63:0] pv;

        pv = 64'h0;
        for (int i = 0; i < 8; i++) begin
            tbl[i].v    = (i < 7);
            tbl[i].d    = (i < 7) ? 56'h12345678123456 : 56'h0;
            tbl[i].eov  = (i >= 1 && i < 7);
            tbl[i].eout = 64'h0;
        end
        tbl[1].eout = 64'h1234567812345612;
        tbl[2].eout = 64'h3456781234561234;
        tbl[3].eout = 64'h5678123456123456;
        tbl[4].eout = 64'h7812345612345678;
        tbl[5].eout = 64'h1234561234567812;
        tbl[6].eout = 64'h3456123456781234;
`ifdef RESP_ADAPTER_FLUSH_EN
        tbl[7].eov  = 1'b1;
        tbl[7].eout = 64'h5600000000000000;
`else
        tbl[7].eov  = 1'b0;
        tbl[7].eout = 64'h3456123456781234;
`endif

        rst    = 1'b0;
        ivalid = 1'b0;
        din    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", dout, 64'h0);
        chk("reset_ovalid", {63'h0, ovalid}, 64'h0);
        rst = 1'b1;

        // Fixed-pattern table, first word sampled on the first edge after release.
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].v, tbl[i].d);
            chk("tbl_ovalid", {63'h0, ovalid}, {63'h0, tbl[i].eov});
            if (tbl[i].eov) chk("tbl_out", dout, tbl[i].eout);
            else if (i > 0) chk("tbl_hold", dout, tbl[i].eout);
        end
        step(1'b0, 56'h0);
        chk("idle_quiet", {63'h0, ovalid}, 64'h0);

        step(1'b1, 56'hAABBCCDDEEFF11);
`ifndef RESP_ADAPTER_FLUSH_EN
        chk("resume_out", dout, 64'h56AABBCCDDEEFF11);
        chk("resume_ovalid", {63'h0, ovalid}, 64'h1);
`else
        chk("resume_noout", {63'h0, ovalid}, 64'h0);
`endif

        // Mid-stream asynchronous reset.
        step(1'b1, 56'h01020304050607);
        step(1'b1, 56'h08090A0B0C0D0E);
        ivalid = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("async_rst_out", dout, 64'h0);
        chk("async_rst_ovalid", {63'h0, ovalid}, 64'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;

        // Counting bytes 0x00..0x37 across 8 inputs -> 7 outputs, alignment returns to 0.
        for (int k = 0; k < 8; k++) begin
            for (int b = 0; b < 7; b++) cw[55-8*b -: 8] = 8'(7*k + b);
            step(1'b1, cw);
            if (k == 1) chk("count_first", dout, 64'h0001020304050607);
            if (k == 7) chk("count_last", dout, 64'h3031323334353637);
        end
        step(1'b1, 56'hFFEEDDCCBBAA99);
        chk("realign_noout", {63'h0, ovalid}, 64'h0);

        // Random data with random idle gaps.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                step(1'b0, 56'h0);
                pv = {63'h0, ovalid};
            end else begin
                step(1'b1, {$urandom, $urandom_range(0, 16777215)});
            end
        end
        for (int k = 0; k < 3; k++) step(1'b0, 56'h0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
